freq_div_ctrl: RTL

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

---
 rtl/freq_div_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable divider with handshaked reconfiguration applied at period wrap; FREQ_DIV_CTRL_HALF_EN adds half-cycle averaging
module freq_div_ctrl #(
  parameter int WIDTH = 8,
  parameter int RST_DIV = 4,
  parameter int RST_HIGH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
`ifdef FREQ_DIV_CTRL_HALF_EN
  input  logic             cfg_half,
`endif
  output logic             cfg_err,
  output logic             q_out,
  output logic             tick,
  output logic             active
);
`ifndef FREQ_DIV_CTRL_HALF_EN
  logic cfg_half;
  assign cfg_half = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] count, count_n, div, div_n, high, high_n, sh_div, sh_high;
  logic half, half_n, sh_half, phase, phase_n, pending, pending_n;
  logic hs, legal, load, apply, wrap, stretch_n, q_n, tick_n, err_n;
  logic [WIDTH:0] len, len_n, hi_n;
  assign cfg_ready = !pending;
  assign active = state != IDLE;
  assign hs = cfg_valid && cfg_ready;
  assign legal = cfg_div > WIDTH'(1) && cfg_high != '0 && cfg_high < cfg_div;
  assign len = {1'b0, div} + (WIDTH+1)'(half && phase);
  assign wrap = state != IDLE && {1'b0, count} + (WIDTH+1)'(1) == len;
  // state and datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      div <= WIDTH'(RST_DIV);
      high <= WIDTH'(RST_HIGH);
      half <= 1'b0;
      sh_div <= '0;
      sh_high <= '0;
      sh_half <= 1'b0;
      phase <= 1'b0;
      pending <= 1'b0;
      q_out <= 1'b0;
      tick <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      div <= div_n;
      high <= high_n;
      half <= half_n;
      sh_div <= hs && legal && state != IDLE ? cfg_div : sh_div;
      sh_high <= hs && legal && state != IDLE ? cfg_high : sh_high;
      sh_half <= hs && legal && state != IDLE ? cfg_half : sh_half;
      phase <= phase_n;
      pending <= pending_n;
      q_out <= q_n;
      tick <= tick_n;
      cfg_err <= err_n;
    end
  // run while enabled; a stop request lets the current period finish first
  always_comb
    state_n = state == IDLE ? (enable ? RUN : IDLE) : enable ? RUN : wrap ? IDLE : STOP;
  // next counter/config values and the registered outputs derived from them
  always_comb begin
    load = hs && legal && state == IDLE;
    apply = pending && (wrap || state == IDLE);
    div_n = load ? cfg_div : apply ? sh_div : div;
    high_n = load ? cfg_high : apply ? sh_high : high;
    half_n = load ? cfg_half : apply ? sh_half : half;
    pending_n = hs && legal && state != IDLE ? 1'b1 : apply ? 1'b0 : pending;
    count_n = state == IDLE || state_n == IDLE || wrap ? '0 : count + WIDTH'(1);
    phase_n = state_n == IDLE || load || apply ? 1'b0 : wrap ? half && !phase : phase;
    stretch_n = half_n && phase_n;
    len_n = {1'b0, div_n} + (WIDTH+1)'(stretch_n);
    hi_n = {1'b0, high_n} + (WIDTH+1)'(stretch_n);
    q_n = state_n != IDLE && {1'b0, count_n} < hi_n;
    tick_n = state_n != IDLE && {1'b0, count_n} + (WIDTH+1)'(1) == len_n;
    err_n = hs && !legal;
  end
endmodule
